// File: rtl/image_rom_arbiter.sv
// Shares one ImageROM port between a never-stalled pixel fetch path and a
// background requester; read data is steered back by an owner tag pipeline.
module image_rom_arbiter #(
    parameter int ADDR_WIDTH   = 17,
    parameter int DATA_WIDTH   = 24,
    parameter int ROM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 1023
) (
    input  logic                  VGA_CLK,
    input  logic                  RST_N,
    input  logic                  pix_req,
    input  logic [ADDR_WIDTH-1:0] pix_addr,
    input  logic                  bg_req,
    input  logic [ADDR_WIDTH-1:0] bg_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  bg_gnt,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic [DATA_WIDTH-1:0] bg_data,
    output logic                  pix_valid,
    output logic                  bg_valid,
    output logic                  bg_starved
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PIX  = 2'd1,
        BG   = 2'd2
    } owner_t;

    owner_t                  w_owner;
    owner_t                  r_state;
    owner_t                  r_tag [1:ROM_LATENCY];
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [CNT_W-1:0]        r_wait;
    logic [CNT_W-1:0]        w_wait_nxt;
    logic                    r_pix_valid;
    logic                    r_bg_valid;
    logic [DATA_WIDTH-1:0]   r_pix_data;
    logic [DATA_WIDTH-1:0]   r_bg_data;
    logic                    r_starved;

    // Owner is decided in the same cycle; r_state (last owner) blocks back-to-back BG grants.
    always_comb begin
        w_owner = IDLE;
        if (RST_N) begin
            if (pix_req)
                w_owner = PIX;
            else if (bg_req && (r_state != BG))
                w_owner = BG;
        end
    end

    always_comb begin
        case (w_owner)
            PIX:     rom_addr = pix_addr;
            BG:      rom_addr = bg_addr;
            default: rom_addr = r_addr;
        endcase
    end

    assign bg_gnt = (w_owner == BG);

    always_comb begin
        w_wait_nxt = r_wait;
        if (!bg_req || bg_gnt)
            w_wait_nxt = '0;
        else if (r_wait != LIMIT)
            w_wait_nxt = r_wait + 1'b1;
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            for (int k = 1; k <= ROM_LATENCY; k++)
                r_tag[k] <= IDLE;
            r_pix_valid <= 1'b0;
            r_bg_valid  <= 1'b0;
            r_pix_data  <= '0;
            r_bg_data   <= '0;
            r_wait      <= '0;
            r_starved   <= 1'b0;
        end else begin
            r_state <= w_owner;
            r_addr  <= rom_addr;
            r_tag[1] <= w_owner;
            for (int k = 2; k <= ROM_LATENCY; k++)
                r_tag[k] <= r_tag[k-1];
            // The tag leaving the pipe lines up with rom_q for the same issue cycle.
            r_pix_valid <= (r_tag[ROM_LATENCY] == PIX);
            r_bg_valid  <= (r_tag[ROM_LATENCY] == BG);
            if (r_tag[ROM_LATENCY] == PIX)
                r_pix_data <= rom_q;
            if (r_tag[ROM_LATENCY] == BG)
                r_bg_data <= rom_q;
            r_wait    <= w_wait_nxt;
            r_starved <= r_starved | (w_wait_nxt == LIMIT);
        end
    end

    assign pix_valid  = r_pix_valid;
    assign bg_valid   = r_bg_valid;
    assign pix_data   = r_pix_data;
    assign bg_data    = r_bg_data;
    assign bg_starved = r_starved;

endmodule
